// File: rtl/vga_capture_if.sv
// Bundle for vga_capture: incoming VGA stream plus the VRAM write port
// and capture status flags.
interface vga_capture_if #(
    parameter int ADDR_W = 19
);
    logic              pix_en;
    logic              vga_h_sync;
    logic              vga_v_sync;
    logic [3:0]        vga_red;
    logic [3:0]        vga_green;
    logic [3:0]        vga_blue;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              frame_done;
    logic              locked;
    logic              sync_err;

    modport master (
        output pix_en, vga_h_sync, vga_v_sync,
        output vga_red, vga_green, vga_blue,
        input  wr_en, wr_addr, wr_data,
        input  frame_done, locked, sync_err
    );

    modport slave (
        input  pix_en, vga_h_sync, vga_v_sync,
        input  vga_red, vga_green, vga_blue,
        output wr_en, wr_addr, wr_data,
        output frame_done, locked, sync_err
    );
endinterface

// File: rtl/vga_capture.sv
// VGA capture receiver: samples sync/RGB on pix_en, tracks frame and
// line timing, writes active pixels to VRAM at y*H_ACTIVE+x.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input logic           clk,
    input logic           rst,
    vga_capture_if.slave  bus
);
    localparam int PW   = $clog2(H_BP + H_ACTIVE);
    localparam int LMAX = (V_BP > V_ACTIVE) ? V_BP : V_ACTIVE;
    localparam int LW   = $clog2(LMAX + 1);

    localparam logic [PW-1:0] FIRST     = PW'(H_BP);
    localparam logic [PW-1:0] LAST      = PW'(H_BP + H_ACTIVE - 1);
    localparam logic [LW-1:0] VBP_END   = LW'(V_BP);
    localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        F_IDLE, F_VSYNC, F_VBP, F_ACTIVE, F_DONE
    } fstate_t;

    typedef enum logic {
        L_WAIT, L_PIX
    } lstate_t;

    fstate_t           fstate;
    lstate_t           lstate;
    logic              stb;
    logic              hs, hs_prev, vs, vs_prev;
    logic [11:0]       rgb;
    logic [PW-1:0]     pcnt;
    logic [LW-1:0]     lcnt;
    logic [ADDR_W-1:0] addr;

    logic          hs_rise, hs_fall, vs_rise, vs_fall;
    logic          start, adv, in_line, wr_pix, last, err;
    logic [PW-1:0] idx;

    assign hs_rise = hs & ~hs_prev;
    assign hs_fall = ~hs & hs_prev;
    assign vs_rise = vs & ~vs_prev;
    assign vs_fall = ~vs & vs_prev;

    // Sample index of the current strobe within the line (0 = hsync rise)
    always_comb begin
        start   = (fstate == F_ACTIVE) && (lstate == L_WAIT) && hs_rise;
        adv     = (fstate == F_ACTIVE) && (lstate == L_PIX);
        idx     = start ? '0 : pcnt + PW'(1);
        in_line = start | adv;
        wr_pix  = in_line && (idx >= FIRST);
        last    = in_line && (idx == LAST);
        err     = stb && (
                  (vs_fall && (fstate == F_VBP || fstate == F_ACTIVE)) ||
                  (adv && hs_fall && !last));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate         <= F_IDLE;
            lstate         <= L_WAIT;
            stb            <= 1'b0;
            hs             <= 1'b1;
            hs_prev        <= 1'b1;
            vs             <= 1'b1;
            vs_prev        <= 1'b1;
            rgb            <= '0;
            pcnt           <= '0;
            lcnt           <= '0;
            addr           <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.frame_done <= 1'b0;
            bus.locked     <= 1'b0;
            bus.sync_err   <= 1'b0;
        end else begin
            bus.wr_en      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.sync_err   <= 1'b0;
            stb            <= bus.pix_en;
            if (bus.pix_en) begin
                hs      <= bus.vga_h_sync;
                hs_prev <= hs;
                vs      <= bus.vga_v_sync;
                vs_prev <= vs;
                rgb     <= {bus.vga_red, bus.vga_green, bus.vga_blue};
            end
            // Logic acts on the strobe after the sample regs load
            if (fstate == F_DONE) begin
                bus.frame_done <= 1'b1;
                bus.locked     <= 1'b1;
                fstate         <= (stb && vs_fall) ? F_VSYNC : F_IDLE;
            end else if (err) begin
                bus.sync_err <= 1'b1;
                bus.locked   <= 1'b0;
                addr         <= '0;
                lstate       <= L_WAIT;
                fstate       <= F_VSYNC;
            end else if (stb) begin
                unique case (fstate)
                    F_IDLE: begin
                        if (vs_fall) fstate <= F_VSYNC;
                    end
                    F_VSYNC: begin
                        if (vs_rise) begin
                            fstate <= F_VBP;
                            lcnt   <= '0;
                        end
                    end
                    F_VBP: begin
                        if (hs_rise) begin
                            if (lcnt + LW'(1) == VBP_END) begin
                                fstate <= F_ACTIVE;
                                lstate <= L_WAIT;
                                lcnt   <= '0;
                                addr   <= '0;
                            end else begin
                                lcnt <= lcnt + LW'(1);
                            end
                        end
                    end
                    F_ACTIVE: begin
                        if (in_line) begin
                            pcnt   <= idx;
                            lstate <= last ? L_WAIT : L_PIX;
                        end
                        if (wr_pix) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= addr;
                            bus.wr_data <= rgb;
                            addr        <= addr + ADDR_W'(1);
                        end
                        if (last) begin
                            lcnt <= lcnt + LW'(1);
                            if (lcnt == LAST_LINE) fstate <= F_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
